// File: rtl/topology_walker_pkg.sv
// topology_walker_pkg: topology table layout constants, decoded entry struct, error codes and walker states.
package topology_walker_pkg;
    localparam logic [31:0] CARBON_TOPOLOGY_SIGNATURE          = 32'h504f5443;
    localparam logic [15:0] CARBON_TOPOLOGY_HEADER_V1_VERSION  = 16'd1;
    localparam int          CARBON_TOPOLOGY_HEADER_BYTES       = 16;
    localparam int          CARBON_TOPOLOGY_ENTRY_BYTES        = 18;
    localparam logic [3:0]  CARBON_TOPOLOGY_HDR_LAST_FIELD     = 4'd5;
    localparam logic [3:0]  CARBON_TOPOLOGY_ENT_LAST_FIELD     = 4'd8;

    typedef struct packed {
        logic [15:0] socket;
        logic [15:0] cluster;
        logic [15:0] core;
        logic [15:0] thread;
        logic [15:0] l1;
        logic [15:0] l2;
        logic [15:0] l3;
        logic [15:0] coh_domain;
        logic [15:0] numa;
    } carbon_topo_entry_t;

    typedef enum logic [2:0] {
        TOPO_ERR_NONE     = 3'd0,
        TOPO_ERR_FAULT    = 3'd1,
        TOPO_ERR_TIMEOUT  = 3'd2,
        TOPO_ERR_BAD_SIG  = 3'd3,
        TOPO_ERR_BAD_VER  = 3'd4,
        TOPO_ERR_BAD_SIZE = 3'd5,
        TOPO_ERR_TOO_MANY = 3'd6
    } carbon_topo_err_e;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_REQ, S_HDR_RSP, S_HDR_CHK, S_ENT_REQ, S_ENT_RSP, S_EMIT, S_DONE, S_ERR
    } walk_state_e;

    // Header: sig@0(32) ver@4 hsize@6 esize@8 count@10 total@12(32); entry fields packed every 2 bytes.
    function automatic logic [31:0] topo_field_off(input logic ent, input logic [3:0] f);
        return ent ? {27'd0, f, 1'b0} : (f == 4'd0) ? 32'd0 : (f == 4'd5) ? 32'd12 : {27'd0, f, 1'b0} + 32'd2;
    endfunction
endpackage

// File: rtl/topology_walker_csr_fetch.sv
// topo_csr_field_fetch: single-outstanding CSR read engine with response timeout.
// The owning FSM says when it is requesting or waiting; this block handles handshakes, half select and timing.
module topo_csr_field_fetch #(
    parameter int ADDR_W      = 32,
    parameter int RSP_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_wait,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_half,
    output logic              o_req_valid,
    output logic [ADDR_W-1:0] o_req_addr,
    input  logic              i_req_ready,
    input  logic              i_rsp_valid,
    input  logic [31:0]       i_rsp_rdata,
    input  logic              i_rsp_fault,
    output logic              o_issued,
    output logic              o_valid,
    output logic              o_fault,
    output logic              o_timeout,
    output logic [31:0]       o_data
);
    logic [31:0] r_timer;

    assign o_req_valid = i_req;
    assign o_req_addr  = i_req ? (i_half ? i_addr - ADDR_W'(2) : i_addr) : '0;
    assign o_issued    = i_req & i_req_ready;
    assign o_valid     = i_wait & i_rsp_valid;
    assign o_fault     = o_valid & i_rsp_fault;
    assign o_data      = i_half ? {16'h0, i_rsp_rdata[31:16]} : i_rsp_rdata;
    // The timer also runs while the request is unaccepted so a dead slave cannot hang the walk.
    assign o_timeout   = (RSP_TIMEOUT != 0) && (i_req | i_wait) && !o_issued && !o_valid &&
                         (r_timer == 32'(RSP_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !(i_req || i_wait) || o_issued || o_valid)
            r_timer <= '0;
        else
            r_timer <= r_timer + 32'd1;
    end
endmodule

// File: rtl/topology_walker.sv
// topology_walker: CSR master that reads and validates the v1 topology header, then streams each decoded entry.
module topology_walker
    import topology_walker_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                MAX_ENTRIES = 64,
    parameter int                RSP_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output carbon_topo_err_e   o_err_code,
    output logic [15:0]        o_entry_count,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [15:0]        o_out_index,
    output carbon_topo_entry_t o_out_entry,
    output logic               o_csr_req_valid,
    input  logic               i_csr_req_ready,
    output logic [ADDR_W-1:0]  o_csr_req_addr,
    output logic               o_csr_req_write,
    input  logic               i_csr_rsp_valid,
    output logic               o_csr_rsp_ready,
    input  logic [DATA_W-1:0]  i_csr_rsp_rdata,
    input  logic               i_csr_rsp_fault
);
    if (DATA_W != 32) begin : g_data_w_check
        $error("topology_walker: only DATA_W=32 is supported");
    end

    walk_state_e       r_state, w_next;
    carbon_topo_err_e  r_err, w_chk;
    logic [3:0]        r_field;
    logic [15:0]       r_idx, r_ver, r_hsize, r_esize, r_count, r_entry_count;
    logic [31:0]       r_sig, r_total, w_rel, w_data;
    logic [8:0][15:0]  r_ent;
    logic              r_done, r_error;
    logic              w_ent, w_hdr_rsp, w_req, w_wait, w_half, w_last, w_emit_last, w_idle;
    logic              w_issued, w_valid, w_fault, w_timeout;

    assign w_idle      = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
    assign w_ent       = (r_state == S_ENT_REQ) || (r_state == S_ENT_RSP);
    assign w_hdr_rsp   = (r_state == S_HDR_RSP);
    assign w_req       = (r_state == S_HDR_REQ) || (r_state == S_ENT_REQ);
    assign w_wait      = w_hdr_rsp || (r_state == S_ENT_RSP);
    assign w_rel       = (w_ent ? 32'(CARBON_TOPOLOGY_HEADER_BYTES) + 32'(r_idx) * 32'(CARBON_TOPOLOGY_ENTRY_BYTES) : 32'd0)
                         + topo_field_off(w_ent, r_field);
    // A 16-bit field in the final word is fetched 2 bytes early so the read never runs past the table.
    assign w_half      = w_ent && (w_rel + 32'd4 > r_total);
    assign w_last      = r_field == (w_ent ? CARBON_TOPOLOGY_ENT_LAST_FIELD : CARBON_TOPOLOGY_HDR_LAST_FIELD);
    assign w_emit_last = r_idx == r_count - 16'd1;
    assign w_chk = (r_sig != CARBON_TOPOLOGY_SIGNATURE)         ? TOPO_ERR_BAD_SIG  :
                   (r_ver != CARBON_TOPOLOGY_HEADER_V1_VERSION) ? TOPO_ERR_BAD_VER  :
                   (r_hsize != 16'(CARBON_TOPOLOGY_HEADER_BYTES) || r_esize != 16'(CARBON_TOPOLOGY_ENTRY_BYTES) ||
                    r_total != 32'(r_hsize) + 32'(r_count) * 32'(r_esize)) ? TOPO_ERR_BAD_SIZE :
                   (32'(r_count) > 32'(MAX_ENTRIES))             ? TOPO_ERR_TOO_MANY : TOPO_ERR_NONE;

    topo_csr_field_fetch #(.ADDR_W(ADDR_W), .RSP_TIMEOUT(RSP_TIMEOUT)) u_fetch (
        .clk(clk), .rst(rst), .i_req(w_req), .i_wait(w_wait),
        .i_addr(BASE_ADDR + ADDR_W'(w_rel)), .i_half(w_half),
        .o_req_valid(o_csr_req_valid), .o_req_addr(o_csr_req_addr), .i_req_ready(i_csr_req_ready),
        .i_rsp_valid(i_csr_rsp_valid), .i_rsp_rdata(i_csr_rsp_rdata), .i_rsp_fault(i_csr_rsp_fault),
        .o_issued(w_issued), .o_valid(w_valid), .o_fault(w_fault), .o_timeout(w_timeout), .o_data(w_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: w_next = i_start ? S_HDR_REQ : r_state;
            S_HDR_REQ, S_ENT_REQ:  w_next = w_issued ? ((r_state == S_HDR_REQ) ? S_HDR_RSP : S_ENT_RSP) :
                                            w_timeout ? S_ERR : r_state;
            S_HDR_RSP, S_ENT_RSP:  w_next = (w_fault || w_timeout) ? S_ERR : !w_valid ? r_state :
                                            !w_last ? (w_hdr_rsp ? S_HDR_REQ : S_ENT_REQ) :
                                            (w_hdr_rsp ? S_HDR_CHK : S_EMIT);
            S_HDR_CHK:             w_next = (w_chk != TOPO_ERR_NONE) ? S_ERR : (r_count == 16'd0) ? S_DONE : S_ENT_REQ;
            S_EMIT:                w_next = !i_out_ready ? S_EMIT : w_emit_last ? S_DONE : S_ENT_REQ;
            default:               w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {r_done, r_error, r_field, r_idx, r_entry_count} <= '0;
            {r_sig, r_ver, r_hsize, r_esize, r_count, r_total, r_ent} <= '0;
            r_err <= TOPO_ERR_NONE;
        end else begin
            if (w_idle && i_start) begin
                {r_done, r_error, r_field, r_idx, r_entry_count} <= '0;
                r_err <= TOPO_ERR_NONE;
            end
            if (w_fault || w_timeout) begin
                r_error <= 1'b1;
                r_err   <= w_fault ? TOPO_ERR_FAULT : TOPO_ERR_TIMEOUT;
            end else if (w_valid) begin
                r_field <= w_last ? 4'd0 : r_field + 4'd1;
                if (w_ent) r_ent[4'd8 - r_field] <= w_data[15:0];
                else case (r_field)
                    4'd0:    r_sig   <= w_data;
                    4'd1:    r_ver   <= w_data[15:0];
                    4'd2:    r_hsize <= w_data[15:0];
                    4'd3:    r_esize <= w_data[15:0];
                    4'd4:    r_count <= w_data[15:0];
                    default: r_total <= w_data;
                endcase
            end
            if (r_state == S_HDR_CHK) begin
                r_idx <= '0;
                if (w_chk != TOPO_ERR_NONE) begin
                    r_error <= 1'b1;
                    r_err   <= w_chk;
                end else begin
                    r_entry_count <= r_count;
                    r_done        <= r_count == 16'd0;
                end
            end
            if (r_state == S_EMIT && i_out_ready) begin
                if (w_emit_last) r_done <= 1'b1;
                else             r_idx  <= r_idx + 16'd1;
            end
        end
    end

    assign o_busy          = !w_idle;
    assign o_done          = r_done;
    assign o_error         = r_error;
    assign o_err_code      = r_err;
    assign o_entry_count   = r_entry_count;
    assign o_out_valid     = r_state == S_EMIT;
    assign o_out_index     = r_idx;
    assign o_out_entry     = carbon_topo_entry_t'(r_ent);
    assign o_csr_req_write = 1'b0;
    assign o_csr_rsp_ready = 1'b1;
endmodule

// File: tb/tb_topology_walker.sv
// tb_topology_walker: walker instances sharing a byte-level topology ROM slave model, checked against decoded entry values.
module tb_topology_walker;
    import topology_walker_pkg::*;
    localparam logic [31:0] BASE = 32'h1000;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1, sel = 1'b0;
    always #5 clk = ~clk;

    logic a_busy, a_done, a_error, a_out_valid, a_req_valid, a_req_write, a_rsp_ready, a_start, a_req_ready, a_rsp_valid;
    logic b_busy, b_done, b_error, b_out_valid, b_req_valid, b_req_write, b_rsp_ready, b_start, b_req_ready, b_rsp_valid;
    logic [15:0] a_entry_count, a_out_index, b_entry_count, b_out_index;
    logic [31:0] a_req_addr, b_req_addr;
    carbon_topo_err_e a_err_code, b_err_code, m_err_code;
    carbon_topo_entry_t a_out_entry, b_out_entry;

    logic s_req_ready = 1'b0, s_rsp_valid = 1'b0, s_fault = 1'b0;
    logic [31:0] s_rdata = '0;

    assign a_start = start & ~sel;
    assign b_start = start & sel;
    assign a_req_ready = ~sel & s_req_ready;
    assign b_req_ready = sel & s_req_ready;
    assign a_rsp_valid = ~sel & s_rsp_valid;
    assign b_rsp_valid = sel & s_rsp_valid;

    topology_walker #(.BASE_ADDR(BASE), .MAX_ENTRIES(64), .RSP_TIMEOUT(8)) u_dut_a (
        .clk(clk), .rst(rst), .i_start(a_start), .o_busy(a_busy), .o_done(a_done), .o_error(a_error),
        .o_err_code(a_err_code), .o_entry_count(a_entry_count), .o_out_valid(a_out_valid), .i_out_ready(out_ready),
        .o_out_index(a_out_index), .o_out_entry(a_out_entry), .o_csr_req_valid(a_req_valid),
        .i_csr_req_ready(a_req_ready), .o_csr_req_addr(a_req_addr), .o_csr_req_write(a_req_write),
        .i_csr_rsp_valid(a_rsp_valid), .o_csr_rsp_ready(a_rsp_ready), .i_csr_rsp_rdata(s_rdata), .i_csr_rsp_fault(s_fault));

    topology_walker #(.BASE_ADDR(BASE), .MAX_ENTRIES(1), .RSP_TIMEOUT(8)) u_dut_b (
        .clk(clk), .rst(rst), .i_start(b_start), .o_busy(b_busy), .o_done(b_done), .o_error(b_error),
        .o_err_code(b_err_code), .o_entry_count(b_entry_count), .o_out_valid(b_out_valid), .i_out_ready(out_ready),
        .o_out_index(b_out_index), .o_out_entry(b_out_entry), .o_csr_req_valid(b_req_valid),
        .i_csr_req_ready(b_req_ready), .o_csr_req_addr(b_req_addr), .o_csr_req_write(b_req_write),
        .i_csr_rsp_valid(b_rsp_valid), .o_csr_rsp_ready(b_rsp_ready), .i_csr_rsp_rdata(s_rdata), .i_csr_rsp_fault(s_fault));

    logic m_busy, m_done, m_error, m_out_valid, m_req_valid, m_rsp_ready;
    logic [15:0] m_entry_count, m_out_index;
    logic [31:0] m_req_addr;
    logic [143:0] m_out_entry;
    assign m_busy        = sel ? b_busy : a_busy;
    assign m_done        = sel ? b_done : a_done;
    assign m_error       = sel ? b_error : a_error;
    assign m_err_code    = sel ? b_err_code : a_err_code;
    assign m_entry_count = sel ? b_entry_count : a_entry_count;
    assign m_out_valid   = sel ? b_out_valid : a_out_valid;
    assign m_out_index   = sel ? b_out_index : a_out_index;
    assign m_out_entry   = sel ? b_out_entry : a_out_entry;
    assign m_req_valid   = sel ? b_req_valid : a_req_valid;
    assign m_req_addr    = sel ? b_req_addr : a_req_addr;
    assign m_rsp_ready   = sel ? b_rsp_ready : a_rsp_ready;

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference table: byte image of the ROM plus the field values each entry must decode to.
    logic [7:0]  rom [0:63];
    logic [15:0] vals [0:1][0:8];

    task automatic wr16(input int off, input logic [15:0] v);
        rom[off] = v[7:0]; rom[off+1] = v[15:8];
    endtask
    task automatic wr32(input int off, input logic [31:0] v);
        wr16(off, v[15:0]); wr16(off + 2, v[31:16]);
    endtask
    task automatic build_rom();
        for (int i = 0; i < 64; i++) rom[i] = 8'h0;
        wr32(0, 32'h504f5443); wr16(4, 16'd1); wr16(6, 16'd16); wr16(8, 16'd18); wr16(10, 16'd2); wr32(12, 32'd52);
        for (int i = 0; i < 2; i++)
            for (int f = 0; f < 9; f++) begin
                vals[i][f] = 16'($urandom);
                wr16(16 + i * 18 + 2 * f, vals[i][f]);
            end
    endtask
    function automatic logic [31:0] rd32(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            int o;
            o = int'(a - BASE) + b;
            if (o >= 0 && o < 64) r[8*b +: 8] = rom[o];
        end
        return r;
    endfunction
    function automatic logic [143:0] exp_ent(input int i);
        logic [143:0] e;
        e = '0;
        for (int f = 0; f < 9; f++) e = {e[127:0], vals[i][f]};
        return e;
    endfunction

    int cyc = 0;
    initial forever @(posedge clk) cyc++;

    // CSR slave: one outstanding read, random 0-2 cycle latency, short random req_ready stalls.
    bit pend = 0, p_req_hs = 0, p_rsp_hs = 0, silent = 0, corrupt_sig = 0, ent_hs = 0;
    int lat = 0, force_lat = -1, stall = 0, hs_cyc = 0;
    logic [31:0] paddr = '0, p_addr = '0, fault_addr = '1;
    initial forever begin
        @(negedge clk);
        if (p_rsp_hs) s_rsp_valid = 1'b0;
        if (p_req_hs) begin
            pend = 1; paddr = p_addr;
            lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 2));
        end
        if (pend && !s_rsp_valid && !silent) begin
            if (lat == 0) begin
                s_rsp_valid = 1'b1;
                s_rdata = (corrupt_sig && paddr == BASE) ? 32'h0 : rd32(paddr);
                s_fault = (paddr == fault_addr);
                pend = 0;
            end else lat--;
        end
        s_req_ready = !pend && !s_rsp_valid && (($urandom_range(0, 3) != 0) || stall >= 2);
        stall = (!pend && !s_rsp_valid && !s_req_ready) ? stall + 1 : 0;
        p_req_hs = m_req_valid && s_req_ready;
        p_addr = m_req_addr;
        if (p_req_hs) begin
            hs_cyc = cyc;
            if (m_req_addr >= BASE + 32'd16) ent_hs = 1;
        end
        p_rsp_hs = s_rsp_valid && m_rsp_ready;
    end

    logic [15:0]  got_idx [$];
    logic [143:0] got_ent [$];
    bit seen_valid = 0;
    initial forever begin
        @(negedge clk); #1;
        if (m_out_valid) seen_valid = 1;
        if (m_out_valid && out_ready) begin
            got_idx.push_back(m_out_index);
            got_ent.push_back(m_out_entry);
        end
    end

    task automatic slave_reset();
        pend = 0; s_rsp_valid = 1'b0; s_req_ready = 1'b0; p_req_hs = 0; p_rsp_hs = 0;
        silent = 0; corrupt_sig = 0; fault_addr = '1; force_lat = -1;
    endtask

    task automatic start_walk();
        got_idx.delete(); got_ent.delete(); seen_valid = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", m_busy, 1);
        chk("count_cleared", m_entry_count, 0);
    endtask

    int end_cyc = 0;
    task automatic wait_end(input string tag, input int budget);
        bit fin;
        fin = 0;
        for (int i = 0; i < budget && !fin; i++) begin
            if (m_done || m_error) fin = 1;
            else @(negedge clk);
        end
        end_cyc = cyc;
        chk({tag, "_finished"}, fin, 1);
        chk({tag, "_done_xor_error"}, m_done & m_error, 0);
    endtask

    task automatic check_ok_walk(input string tag);
        chk({tag, "_done"}, m_done, 1);
        chk({tag, "_error"}, m_error, 0);
        chk({tag, "_err_code"}, m_err_code, TOPO_ERR_NONE);
        chk({tag, "_entry_count"}, m_entry_count, 2);
        chk({tag, "_n_entries"}, got_idx.size(), 2);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_index%0d", tag, i), got_idx[i], i);
            chk($sformatf("%s_entry%0d", tag, i), got_ent[i], exp_ent(i));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [143:0] snap;
        logic [15:0] snap_idx;
        int bad_stab, bad_req;
        bit reached;
        build_rom();
        repeat (4) @(negedge clk);
        chk("rst_busy", a_busy, 0); chk("rst_done", a_done, 0); chk("rst_error", a_error, 0);
        chk("rst_err_code", a_err_code, TOPO_ERR_NONE); chk("rst_entry_count", a_entry_count, 0);
        chk("rst_out_valid", a_out_valid, 0); chk("rst_out_index", a_out_index, 0);
        chk("rst_req_valid", a_req_valid, 0); chk("rst_req_addr", a_req_addr, 0);
        chk("rst_req_write", a_req_write, 0); chk("rst_b_busy", b_busy, 0);
        rst = 1'b0;

        // Full walk with out_ready held high.
        start_walk(); wait_end("t1", 1000); check_ok_walk("t1");

        // Back-pressure on entry 0: output must hold and no CSR traffic may start.
        out_ready = 1'b0;
        start_walk();
        reached = 0;
        for (int i = 0; i < 500 && !reached; i++) begin
            if (m_out_valid) reached = 1;
            else @(negedge clk);
        end
        chk("t2_emit_reached", reached, 1);
        snap = m_out_entry; snap_idx = m_out_index; bad_stab = 0; bad_req = 0;
        repeat (20) begin
            @(negedge clk);
            if (!m_out_valid || m_out_entry !== snap || m_out_index !== snap_idx) bad_stab++;
            if (m_req_valid) bad_req++;
        end
        chk("t2_stall_stable", bad_stab, 0);
        chk("t2_stall_no_req", bad_req, 0);
        chk("t2_stall_entry0", snap, exp_ent(0));
        out_ready = 1'b1;
        wait_end("t2", 1000); check_ok_walk("t2");

        // Corrupt signature.
        @(negedge clk); #2; corrupt_sig = 1;
        start_walk(); wait_end("t3", 1000);
        chk("t3_error", m_error, 1); chk("t3_err_code", m_err_code, TOPO_ERR_BAD_SIG);
        chk("t3_no_out_valid", seen_valid, 0); chk("t3_entry_count", m_entry_count, 0);
        @(negedge clk); #2; slave_reset();

        // Fault on entry 1 field 3.
        fault_addr = BASE + 32'd16 + 32'd18 + 32'd6;
        start_walk(); wait_end("t4", 1000);
        chk("t4_error", m_error, 1); chk("t4_err_code", m_err_code, TOPO_ERR_FAULT);
        chk("t4_n_entries", got_idx.size(), 1);
        chk("t4_index0", got_idx[0], 0); chk("t4_entry0", got_ent[0], exp_ent(0));
        @(negedge clk); #2; slave_reset();

        // MAX_ENTRIES=1 instance sees a 2-entry table.
        sel = 1'b1;
        start_walk(); wait_end("t5a", 1000);
        chk("t5a_error", m_error, 1); chk("t5a_err_code", m_err_code, TOPO_ERR_TOO_MANY);
        chk("t5a_entry_count", m_entry_count, 0); chk("t5a_no_out_valid", seen_valid, 0);
        @(negedge clk); sel = 1'b0;

        // Silent slave: request accepted, response never comes.
        @(negedge clk); #2; silent = 1;
        start_walk(); wait_end("t5b", 200);
        chk("t5b_error", m_error, 1); chk("t5b_err_code", m_err_code, TOPO_ERR_TIMEOUT);
        chk("t5b_timeout_cycles", end_cyc - hs_cyc, 9);
        @(negedge clk); #2; slave_reset();

        // Reset while waiting for an entry response; late response must be discarded.
        force_lat = 2; ent_hs = 0;
        start_walk();
        reached = 0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk); #2;
            if (ent_hs) reached = 1;
        end
        chk("t6_entry_req_reached", reached, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("t6_rst_busy", m_busy, 0); chk("t6_rst_out_valid", m_out_valid, 0);
        chk("t6_rst_req_valid", m_req_valid, 0); chk("t6_rst_error", m_error, 0);
        repeat (6) @(negedge clk);
        #2; force_lat = -1;
        start_walk(); wait_end("t6", 1000); check_ok_walk("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
